cover_toggle_sched: RTL

Toggle-coverage hit scheduler between the per-module toggle-cover groups and the single shared coverage-report channel. It captures up to `WIDTH` hit strobes per cycle into a pending bitmap and arbitrates them round-robin. It then emits one absolute cover index per handshake to the downstream sink, which is either the DPI reporter or the hardware bitmap writer. Optional de-duplication keeps a bit from being reported more than once until software clears it.

---
 rtl/cover_toggle_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cover_toggle_sched.sv
// Toggle-coverage hit scheduler: latches per-bit hit strobes into a pending map and
// emits one absolute cover index per valid/ready handshake, round-robin across bits.
// Latency: hit in cycle N -> out_valid/out_index in cycle N+2.
// Backpressure: out_index holds while out_valid & ~out_ready; hits merge into pending meanwhile.
//
// Ports:
//   clock, reset (async, active-low)    - clocking and reset
//   enable, valid[WIDTH]                - hit capture enable and per-bit hit strobes
//   clear                               - one-cycle pulse, wipes pending (and done) after draining the slot
//   out_valid/out_ready/out_index       - downstream index handshake
//   hit_count                           - saturating count of accepted indices
//   busy                                - work pending, index presented, or clear in progress
// Optional feature macro: COVER_TOGGLE_DEDUP_EN (done mask, report each bit once until clear).
module cover_toggle_sched #(
  parameter int     WIDTH       = 20,
  parameter longint COVER_INDEX = 0,
  parameter int     IDX_W       = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] valid,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [31:0]      hit_count,
  output logic             busy
);

  localparam int RR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CLR  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] w_pending_nxt;
  logic [WIDTH-1:0] w_capture;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_grant_mask;
  logic [RR_W-1:0]  r_rr;
  logic [RR_W-1:0]  w_rr_inc;
  logic [RR_W-1:0]  w_win;
  logic [RR_W-1:0]  w_cand;
  logic             w_found;
  logic             w_slot_free;
  logic             w_grant;
  logic             r_out_valid;
  logic [IDX_W-1:0] r_out_index;
  logic [31:0]      r_hit_count;

  // Round-robin search: walk candidates from the highest offset down so the last
  // match written is the lowest offset from rr, i.e. the first set bit at/after rr.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      w_cand = RR_W'((int'(r_rr) + k) % WIDTH);
      if (r_pending[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_slot_free  = ~r_out_valid | out_ready;
  assign w_grant      = (r_state == S_IDLE) & w_slot_free & w_found;
  assign w_grant_mask = w_grant ? (WIDTH'(1) << w_win) : '0;
  assign w_rr_inc     = (w_win == RR_W'(WIDTH - 1)) ? '0 : w_win + 1'b1;

`ifdef COVER_TOGGLE_DEDUP_EN
  logic [WIDTH-1:0] r_done;

  // The grant mask is included so a hit landing in the grant cycle is
  // suppressed rather than re-arming the bit that was just reported.
  assign w_mask = r_done | w_grant_mask;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_done <= '0;
    end else if (r_state == S_CLR) begin
      r_done <= '0;
    end else begin
      r_done <= r_done | w_grant_mask;
    end
  end
`else
  assign w_mask = '0;
`endif

  // Pending update: granted bit clears, but a same-cycle hit re-arms it
  // (unless masked). CLR keeps only this cycle's hits.
  always_comb begin
    w_capture     = enable ? (valid & ~w_mask) : '0;
    w_pending_nxt = (r_pending & ~w_grant_mask) | w_capture;
    if (r_state == S_CLR) begin
      w_pending_nxt = enable ? valid : '0;
    end
  end

  // Clear sequencing: WAIT lets an in-flight index drain before CLR wipes state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (clear) w_state_nxt = S_WAIT;
      S_WAIT:  if (~r_out_valid | out_ready) w_state_nxt = S_CLR;
      S_CLR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pending   <= '0;
      r_rr        <= '0;
      r_out_valid <= 1'b0;
      r_out_index <= '0;
      r_hit_count <= '0;
    end else begin
      r_pending <= w_pending_nxt;

      if (r_state == S_CLR) begin
        r_rr <= '0;
      end else if (w_grant) begin
        r_rr <= w_rr_inc;
      end

      if (w_grant) begin
        r_out_valid <= 1'b1;
        r_out_index <= IDX_W'(COVER_INDEX) + IDX_W'(w_win);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (r_out_valid && out_ready && (r_hit_count != 32'hFFFF_FFFF)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_index = r_out_index;
  assign hit_count = r_hit_count;
  assign busy      = (|r_pending) | r_out_valid | (r_state != S_IDLE);

endmodule
